// File: rtl/jt49_mix_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jt49_mix_seq : time-multiplexed tone/noise mixer and amplitude stage     |
// |                producing per-channel 5-bit levels and a summed sample.   |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module jt49_mix_seq #(
  parameter int FIXED_LSB = 0,
  parameter int SUM_W     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic [2:0]       tone,
  input  logic             noise,
  input  logic [5:0]       mix,
  input  logic [4:0]       amp_a,
  input  logic [4:0]       amp_b,
  input  logic [4:0]       amp_c,
  input  logic [4:0]       env,
  output logic [4:0]       vol_a,
  output logic [4:0]       vol_b,
  output logic [4:0]       vol_c,
  output logic [SUM_W-1:0] sum,
  output logic             sample
);

  typedef enum logic [1:0] {
    PH_A   = 2'd0,
    PH_B   = 2'd1,
    PH_C   = 2'd2,
    PH_BAD = 2'd3
  } phase_t;

  phase_t           phase_q, phase_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [4:0]       vol_a_q, vol_a_d;
  logic [4:0]       vol_b_q, vol_b_d;
  logic [4:0]       vol_c_q, vol_c_d;
  logic             sample_q, sample_d;

  logic [4:0]       amp_sel;
  logic             tone_bit;
  logic             tone_dis;
  logic             noise_dis;
  logic [4:0]       fixed_lvl;
  logic [4:0]       src_lvl;
  logic             gate;
  logic [4:0]       lvl;
  logic [SUM_W-1:0] lvl_ext;

  // Shared datapath: route the active channel's controls into one mixer.
  always_comb begin
    amp_sel   = amp_a;
    tone_bit  = tone[0];
    tone_dis  = mix[0];
    noise_dis = mix[3];
    case (phase_q)
      PH_B: begin
        amp_sel   = amp_b;
        tone_bit  = tone[1];
        tone_dis  = mix[1];
        noise_dis = mix[4];
      end
      PH_C: begin
        amp_sel   = amp_c;
        tone_bit  = tone[2];
        tone_dis  = mix[2];
        noise_dis = mix[5];
      end
      default: ;
    endcase

    fixed_lvl = {amp_sel[3:0], (FIXED_LSB != 0) ? 1'b1 : (|amp_sel[3:0])};
    src_lvl   = amp_sel[4] ? env : fixed_lvl;
    gate      = (tone_bit | tone_dis) & (noise | noise_dis);
    lvl       = gate ? src_lvl : 5'd0;
    lvl_ext   = {{(SUM_W-5){1'b0}}, lvl};
  end

  always_comb begin
    phase_d  = phase_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    vol_a_d  = vol_a_q;
    vol_b_d  = vol_b_q;
    vol_c_d  = vol_c_q;
    sample_d = 1'b0;
    if (cen) begin
      case (phase_q)
        PH_A: begin
          vol_a_d = lvl;
          acc_d   = lvl_ext;
          phase_d = PH_B;
        end
        PH_B: begin
          vol_b_d = lvl;
          acc_d   = acc_q + lvl_ext;
          phase_d = PH_C;
        end
        PH_C: begin
          vol_c_d  = lvl;
          sum_d    = acc_q + lvl_ext;
          sample_d = 1'b1;
          phase_d  = PH_A;
        end
        default: phase_d = PH_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_A;
      acc_q    <= '0;
      sum_q    <= '0;
      vol_a_q  <= 5'd0;
      vol_b_q  <= 5'd0;
      vol_c_q  <= 5'd0;
      sample_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      vol_a_q  <= vol_a_d;
      vol_b_q  <= vol_b_d;
      vol_c_q  <= vol_c_d;
      sample_q <= sample_d;
    end
  end

  assign vol_a  = vol_a_q;
  assign vol_b  = vol_b_q;
  assign vol_c  = vol_c_q;
  assign sum    = sum_q;
  assign sample = sample_q;

endmodule
`default_nettype wire

// File: doc/jt49_mix_seq.md
Name: jt49_mix_seq

Overview:
- Per-channel mixer and amplitude stage. It sits directly downstream of the tone generators and the noise generator.
- Combines each channel's tone bit with the shared noise bit under control of the mixer-enable register.
- Selects either the channel's fixed level or the envelope level for each channel.
- Time-multiplexes one datapath across channels A, B, C on successive cen pulses.
- Produces registered 5-bit levels per channel plus a summed level with a sample strobe for the DAC/log-table stage.

Parameters:
- FIXED_LSB, 0, mapping of the 4-bit fixed level L to 5 bits. 0: {L, L!=0}. 1: {L, 1'b1}.
- SUM_W, 7, width of the summed output. Must be >= 7, since max sum is 3*31=93.

Ports:
- clk  in  1  core clock (same divided clock the tone/noise generators use)
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; all state advances only on clk edges with cen=1
- tone  in  3  tone generator outputs; bit0=A, bit1=B, bit2=C
- noise  in  1  noise generator output
- mix  in  6  mixer register, 1 = disabled; [2:0] tone disable A/B/C, [5:3] noise disable A/B/C
- amp_a  in  5  channel A amplitude register; [4]=envelope mode, [3:0]=fixed level
- amp_b  in  5  channel B amplitude register, same format
- amp_c  in  5  channel C amplitude register, same format
- env  in  5  current envelope level
- vol_a  out  5  registered level, channel A
- vol_b  out  5  registered level, channel B
- vol_c  out  5  registered level, channel C
- sum  out  SUM_W  registered vol_a+vol_b+vol_c of the last completed pass
- sample  out  1  one-clk pulse: sum updated

Behaviour:
- Reset (rst_n low, asynchronous):
  - phase=0, acc=0.
  - vol_a/b/c=0, sum=0, sample=0.
  - Release is synchronous to the next clk edge.
- Phase counter (0,1,2):
  - Advances only on clk edges with cen=1.
  - Sequence is 0→1→2→0. Value 3 is unreachable; if ever reached, the next cen edge forces 0.
- Channel k = phase, computed on a cen edge:
  - gate = (tone[k] | mix[k]) & (noise | mix[k+3]).
  - src = amp_k[4] ? env : fixed5(amp_k[3:0]) per FIXED_LSB.
  - lvl = gate ? src : 0.
  - vol_k <= lvl. The other vol outputs hold.
- Inputs are sampled only at the cen edge of their own phase. Changes between phases affect only the channel being computed.
- Accumulator, on cen edges:
  - Phase 0: acc <= lvl.
  - Phase 1: acc <= acc + lvl.
  - Phase 2: sum <= acc + lvl, zero-extended to SUM_W. acc is don't-care afterwards and is reloaded at phase 0.
- sample:
  - Registered. High for exactly one clk cycle, on the clk edge where cen=1 and phase=2.
  - Low at all other times, including cen=0 cycles.
- Latency:
  - vol_k reflects inputs 1 clk after its phase's cen edge.
  - sum reflects a full A/B/C pass 1 clk after the phase-2 cen edge.
  - A new sum is produced every 3 cen pulses.
- cen held low: every register holds and sample stays 0.
- mix=6'h3F: gate=1 constantly, so each output equals its src level (AY DC-level behaviour).
- No overflow: sum width guarantees 93 is representable. No saturation logic.
- Reset mid-pass: the partial accumulation is discarded, no sample is issued, and the next pass starts at channel A.

Test Plan:
- Reset, then 3 cen pulses with mix=6'h3F, amp_a=5'h0F, amp_b=5'h08, amp_c=5'h00, FIXED_LSB=0 → vol_a=5'h1F, vol_b=5'h11, vol_c=0, sum=48, sample a single 1-clk pulse after the 3rd cen.
- Envelope select: amp_a=amp_b=amp_c=5'h10, env=5'h1F, mix=6'h3F → all vol=31, sum=93. Repeat with env=0 → sum=0.
- Gating: mix=6'b111_000, tone=3'b101, noise=0, all fixed level 4'hF → vol_a=31, vol_b=0, vol_c=31. Then mix=6'b000_111, noise=0 → all 0; noise=1 → all 31.
- cen duty: cen high every 4th clk → phase and outputs change only on cen edges; sample rate one per 12 clks, each pulse 1 clk wide. cen held low 50 clks → no change, no pulse.
- Reset mid-pass: assert rst_n low after the phase-1 cen edge → all outputs 0 immediately (asynchronous), no pulse. After release, the first cen updates vol_a.
- FIXED_LSB=1: amp_a=5'h00, mix=6'h3F → vol_a=5'h01. FIXED_LSB=0 → vol_a=0.
